bus_mem_serv: RTL and testbench

- Parametrised, synthesizable bus-side memory server for the SDIO host DMA port. It is the next-generation replacement for the behavioural DMA service model.
- Accepts single-beat reads and writes on the sdio_top bus interface. Returns read data after a fixed, configurable latency, fully pipelined.
- Optional pseudo-random back-pressure on bus_ready stresses the host DMA engine.
- Exposes accept counters, a write checksum and a protocol-error flag for self-checking benches.

---
 rtl/bus_mem_serv.sv | 118 +++++++++++
 tb/tb_bus_mem_serv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_serv.sv
// Bus-side memory server for the SDIO host DMA port: single-beat reads/writes,
// fixed-latency pipelined read return, LFSR back-pressure and bench-facing statistics.
module bus_mem_serv #(
  parameter int DW        = 8,
  parameter int AW        = 17,
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 2
) (
  input  logic          bus_clk,
  input  logic          rst,
  input  logic          bus_rd,
  input  logic          bus_wr,
  input  logic [AW-1:0] bus_addr,
  input  logic [DW-1:0] bus_wdata,
  output logic          bus_ready,
  output logic          bus_rdata_ready,
  output logic [DW-1:0] bus_rdata,
  input  logic          stall_en,
  input  logic [7:0]    stall_seed,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_sum,
  output logic          err_both
);

  localparam int IW = $clog2(MEM_DEPTH);

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [DW-1:0]   mem_q [MEM_DEPTH];
  logic [IW-1:0]   idx;
  logic            unused_addr;
  logic            rst_q;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            acc_wr, acc_rd, req_both;
  logic [15:0]     wr_cnt_q, rd_cnt_q, wr_sum_q;
  logic            err_q;
  logic [RD_LAT-1:0] vld_q, sin_vld;
  logic [DW-1:0]   dat_q   [RD_LAT];
  logic [DW-1:0]   sin_dat [RD_LAT];

  // Upper address bits alias onto the same words.
  assign idx         = bus_addr[IW-1:0];
  assign unused_addr = ^bus_addr;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    if (rst) lfsr_d = (stall_seed == 8'h00) ? 8'h01 : stall_seed;
  end

  always_ff @(posedge bus_clk) begin
    rst_q  <= rst;
    lfsr_q <= lfsr_d;
  end

  assign bus_ready = ~rst_q & ~(stall_en & lfsr_q[0]);
  assign acc_wr    = bus_wr & ~bus_rd & bus_ready;
  assign acc_rd    = bus_rd & ~bus_wr & bus_ready;
  assign req_both  = bus_wr & bus_rd & bus_ready;

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_sum_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (acc_wr) begin
        wr_cnt_q <= sat_inc(wr_cnt_q);
        wr_sum_q <= wr_sum_q + 16'(bus_wdata);
      end
      if (acc_rd)   rd_cnt_q <= sat_inc(rd_cnt_q);
      if (req_both) err_q    <= 1'b1;
    end
  end

  // Memory is deliberately left out of reset so contents survive rst.
  always_ff @(posedge bus_clk) begin
    if (acc_wr && !rst) mem_q[idx] <= bus_wdata;
  end

  always_comb begin
    sin_vld[0] = acc_rd;
    sin_dat[0] = mem_q[idx];
    for (int k = 1; k < RD_LAT; k++) begin
      sin_vld[k] = vld_q[k-1];
      sin_dat[k] = dat_q[k-1];
    end
  end

  // Read pipeline: stage RD_LAT-1 is the registered response; data only moves with its valid.
  always_ff @(posedge bus_clk) begin
    if (rst) begin
      vld_q             <= '0;
      dat_q[RD_LAT-1]   <= '0;
    end else begin
      vld_q <= sin_vld;
      if (sin_vld[RD_LAT-1]) dat_q[RD_LAT-1] <= sin_dat[RD_LAT-1];
    end
    for (int k = 0; k < RD_LAT - 1; k++) begin
      if (sin_vld[k]) dat_q[k] <= sin_dat[k];
    end
  end

  assign bus_rdata_ready = vld_q[RD_LAT-1];
  assign bus_rdata       = dat_q[RD_LAT-1];
  assign wr_cnt          = wr_cnt_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_sum          = wr_sum_q;
  assign err_both        = err_q;

endmodule

// File: tb/tb_bus_mem_serv.sv
// Scoreboard bench for bus_mem_serv: two instances (read latency 2 and 4) share one
// request stream; each read pushes its expected data and due cycle per instance.
module tb_bus_mem_serv;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_rd = 1'b0, bus_wr = 1'b0;
  logic [16:0] bus_addr = '0;
  logic [7:0]  bus_wdata = '0;
  logic        stall_en = 1'b0;
  logic [7:0]  stall_seed = 8'h00;

  logic        ready2, rv2, er2, ready4, rv4, er4;
  logic [7:0]  rd2, rd4;
  logic [15:0] wc2, rc2, ws2, wc4, rc4, ws4;

  exp_t        q2[$], q4[$];
  logic [7:0]  mem_m [1024];
  int          wr_m, rd_m;
  logic [15:0] sum_m;
  logic        err_m;
  logic [7:0]  lfsr_m;
  logic        rstq_m;
  int          cyc = 0;
  bit          rdy_chk = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  bus_mem_serv #(.DW(8), .AW(17), .MEM_DEPTH(1024), .RD_LAT(2)) u2 (
    .bus_clk(clk), .rst(rst), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(ready2), .bus_rdata_ready(rv2), .bus_rdata(rd2),
    .stall_en(stall_en), .stall_seed(stall_seed), .wr_cnt(wc2), .rd_cnt(rc2),
    .wr_sum(ws2), .err_both(er2));

  bus_mem_serv #(.DW(8), .AW(17), .MEM_DEPTH(1024), .RD_LAT(4)) u4 (
    .bus_clk(clk), .rst(rst), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(ready4), .bus_rdata_ready(rv4), .bus_rdata(rd4),
    .stall_en(stall_en), .stall_seed(stall_seed), .wr_cnt(wc4), .rd_cnt(rc4),
    .wr_sum(ws4), .err_both(er4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference back-pressure model and response monitor, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    lfsr_m = rst ? ((stall_seed == 8'h00) ? 8'h01 : stall_seed)
                 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    rstq_m = rst;
    #1;
    if (rdy_chk) begin
      check("ready2", {31'd0, ready2}, {31'd0, ~rstq_m & ~(stall_en & lfsr_m[0])});
      check("ready4", {31'd0, ready4}, {31'd0, ~rstq_m & ~(stall_en & lfsr_m[0])});
    end
    if (rv2) begin
      if (q2.size() == 0) check("rd2_spurious", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("rd2_data", {24'd0, rd2}, {24'd0, e.d});
        check("rd2_cycle", cyc, e.due);
      end
    end
    if (rv4) begin
      if (q4.size() == 0) check("rd4_spurious", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("rd4_data", {24'd0, rd4}, {24'd0, e.d});
        check("rd4_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic is_wr, input logic [16:0] a, input logic [7:0] d);
    int w = 0;
    exp_t e;
    @(negedge clk);
    bus_wr = is_wr; bus_rd = ~is_wr; bus_addr = a; bus_wdata = d;
    #1;
    while (!ready2 && w < 64) begin
      @(negedge clk); #1; w++;
    end
    if (!ready2) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (is_wr) begin
      mem_m[a[9:0]] = d; wr_m++; sum_m = sum_m + 16'(d);
    end else begin
      rd_m++;
      e.d = mem_m[a[9:0]];
      e.due = cyc + 2; q2.push_back(e);
      e.due = cyc + 4; q4.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus_rd = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_wc2"}, {16'd0, wc2}, wr_m);
    check({tag, "_rc2"}, {16'd0, rc2}, rd_m);
    check({tag, "_ws2"}, {16'd0, ws2}, {16'd0, sum_m});
    check({tag, "_er2"}, {31'd0, er2}, {31'd0, err_m});
    check({tag, "_wc4"}, {16'd0, wc4}, wr_m);
    check({tag, "_rc4"}, {16'd0, rc4}, rd_m);
    check({tag, "_ws4"}, {16'd0, ws4}, {16'd0, sum_m});
    check({tag, "_er4"}, {31'd0, er4}, {31'd0, err_m});
  endtask

  task automatic drain();
    int w = 0;
    while ((q2.size() != 0 || q4.size() != 0) && w < 40) begin
      @(negedge clk); w++;
    end
    check("drain_q2", q2.size(), 32'd0);
    check("drain_q4", q4.size(), 32'd0);
  endtask

  task automatic do_reset(input logic [7:0] seed);
    int r;
    @(negedge clk);
    rst = 1'b1; bus_rd = 1'b0; bus_wr = 1'b0; stall_seed = seed;
    r = cyc + 1;
    while (q2.size() != 0 && q2[$].due >= r) void'(q2.pop_back());
    while (q4.size() != 0 && q4[$].due >= r) void'(q4.pop_back());
    wr_m = 0; rd_m = 0; sum_m = '0; err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready2", {31'd0, ready2}, 32'd0);
    check("rst_rv2", {31'd0, rv2}, 32'd0);
    check("rst_rdata2", {24'd0, rd2}, 32'd0);
    check("rst_rv4", {31'd0, rv4}, 32'd0);
    check("rst_rdata4", {24'd0, rd4}, 32'd0);
    chk_cnt("rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    wr_m = 0; rd_m = 0; sum_m = '0; err_m = 1'b0;
    repeat (2) @(negedge clk);

    // Basic write then read, latency and counters.
    do_reset(8'h00);
    rdy_chk = 1'b1;
    issue(1'b1, 17'h00010, 8'hA5);
    issue(1'b0, 17'h00010, 8'h00);
    idle();
    drain();
    chk_cnt("t1");
    check("t1_sum_const", {16'd0, ws2}, 32'h00A5);

    // Aliasing and read/write hazards.
    issue(1'b1, 17'h00400, 8'h3C);
    issue(1'b0, 17'h00000, 8'h00);
    issue(1'b1, 17'h00005, 8'h11);
    issue(1'b0, 17'h00005, 8'h00);
    issue(1'b1, 17'h00005, 8'h22);
    issue(1'b0, 17'h10005, 8'h00);
    idle();
    drain();
    chk_cnt("t3");

    // Streaming writes then back-to-back reads.
    do_reset(8'h00);
    for (int i = 0; i < 512; i++) issue(1'b1, 17'(i), 8'(i));
    for (int i = 0; i < 512; i++) issue(1'b0, 17'(i), 8'h00);
    idle();
    drain();
    chk_cnt("t2");
    check("t2_sum_const", {16'd0, ws2}, 32'h0000FF00);

    // Simultaneous read and write: flagged, nothing accepted.
    @(negedge clk);
    bus_rd = 1'b1; bus_wr = 1'b1; bus_addr = 17'h00010; bus_wdata = 8'hEE;
    err_m = 1'b1;
    idle();
    #1;
    chk_cnt("t4a");
    repeat (5) @(negedge clk);
    chk_cnt("t4b");
    issue(1'b0, 17'h00010, 8'h00);
    idle();
    drain();

    // Random back-pressure with a zero seed.
    stall_en = 1'b1;
    do_reset(8'h00);
    for (int i = 0; i < 64; i++) issue(1'b1, 17'h00100 + 17'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 64; i++) issue(1'b0, 17'h00100 + 17'(i), 8'h00);
    idle();
    drain();
    chk_cnt("t5");

    // Reset with reads in flight; memory survives.
    stall_en = 1'b0;
    do_reset(8'h05);
    issue(1'b0, 17'h00030, 8'h00);
    issue(1'b0, 17'h00031, 8'h00);
    do_reset(8'h05);
    repeat (6) @(negedge clk);
    issue(1'b0, 17'h00030, 8'h00);
    idle();
    drain();
    chk_cnt("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
